// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  // Transmit FSM states, one per section of an 8N1 frame plus idle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  // 115200 baud from a 50 MHz clock: 50e6 / 115200 - 1.
  localparam logic [15:0] UART_DIV_DEFAULT = 16'd433;

  // True when the bit index points at the last data bit of the frame.
  function automatic logic is_last_data_bit(input logic [2:0] idx);
    return (idx == 3'(UART_DATA_BITS - 1));
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered level; reads see only committed data.
module uart_tx_fifo #(
  parameter int DEPTH     = 8,
  parameter int LVL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  input  logic                 rd_en,
  output logic [7:0]           rd_data,
  output logic [LVL_WIDTH-1:0] level,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_WIDTH-1:0] LVL_FULL = LVL_WIDTH'(DEPTH);
  localparam logic [LVL_WIDTH-1:0] LVL_ONE  = LVL_WIDTH'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);

  logic [7:0]           mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [LVL_WIDTH-1:0] level_r;
  logic                 wr_ok_s;
  logic                 rd_ok_s;

  assign full    = (level_r == LVL_FULL);
  assign empty   = (level_r == {LVL_WIDTH{1'b0}});
  assign level   = level_r;
  assign rd_data = mem_r[rd_ptr_r];

  // A write into a full FIFO is dropped; a read from an empty one is ignored.
  always_comb begin
    wr_ok_s = wr_en & ~full;
    rd_ok_s = rd_en & ~empty;
  end

  // Storage array; entries need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_WIDTH{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit back-end: byte FIFO feeding an 8N1 serialiser with a
// per-frame latched baud divisor.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [7:0]           push_data_i,
  output logic                 push_ready_o,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic [LVL_WIDTH-1:0] level_o,
  output logic                 overflow_o,
  input  logic                 ovf_clr_i
);

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [LVL_WIDTH-1:0] LVL_ONE  = LVL_WIDTH'(1);

  tx_state_e            state_r;
  tx_state_e            state_nxt_s;
  logic [DIV_WIDTH-1:0] baud_cnt_r;
  logic [DIV_WIDTH-1:0] baud_nxt_s;
  logic [DIV_WIDTH-1:0] div_r;
  logic [DIV_WIDTH-1:0] div_nxt_s;
  logic [2:0]           bit_idx_r;
  logic [2:0]           bit_nxt_s;
  logic [7:0]           shift_r;
  logic [7:0]           shift_nxt_s;
  logic                 tx_r;
  logic                 tx_nxt_s;
  logic                 busy_r;
  logic                 busy_nxt_s;
  logic                 ovf_r;
  logic                 pop_s;
  logic                 push_ok_s;
  logic [LVL_WIDTH-1:0] level_nxt_s;

  logic [7:0]           fifo_rd_data_s;
  logic [LVL_WIDTH-1:0] fifo_level_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;

  uart_tx_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .LVL_WIDTH (LVL_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_i),
    .wr_data (push_data_i),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_data_s),
    .level   (fifo_level_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign push_ready_o = ~fifo_full_s;
  assign level_o      = fifo_level_s;
  assign tx_o         = tx_r;
  assign busy_o       = busy_r;
  assign overflow_o   = ovf_r;

  // FSM state and serialiser datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      baud_cnt_r <= DIV_ZERO;
      div_r      <= DIV_ZERO;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      baud_cnt_r <= baud_nxt_s;
      div_r      <= div_nxt_s;
      bit_idx_r  <= bit_nxt_s;
      shift_r    <= shift_nxt_s;
    end
  end

  // Next-state logic: bit timing, frame sequencing and FIFO pops.
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_cnt_r;
    div_nxt_s   = div_r;
    bit_nxt_s   = bit_idx_r;
    shift_nxt_s = shift_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          shift_nxt_s = fifo_rd_data_s;
          div_nxt_s   = div_i;
          baud_nxt_s  = div_i;
          bit_nxt_s   = 3'd0;
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (baud_cnt_r == DIV_ZERO) begin
          baud_nxt_s  = div_r;
          bit_nxt_s   = 3'd0;
          state_nxt_s = DATA;
        end else begin
          baud_nxt_s  = baud_cnt_r - DIV_ONE;
        end
      end
      DATA: begin
        if (baud_cnt_r == DIV_ZERO) begin
          baud_nxt_s = div_r;
          if (is_last_data_bit(bit_idx_r)) begin
            state_nxt_s = STOP;
          end else begin
            bit_nxt_s   = bit_idx_r + 3'd1;
            shift_nxt_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          baud_nxt_s = baud_cnt_r - DIV_ONE;
        end
      end
      STOP: begin
        if (baud_cnt_r == DIV_ZERO) begin
          // Chain straight into the next frame when more data is waiting.
          if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            shift_nxt_s = fifo_rd_data_s;
            div_nxt_s   = div_i;
            baud_nxt_s  = div_i;
            bit_nxt_s   = 3'd0;
            state_nxt_s = START;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          baud_nxt_s = baud_cnt_r - DIV_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered pin lines up
  // with the state it belongs to.
  always_comb begin
    push_ok_s = push_i & ~fifo_full_s;
    case ({push_ok_s, pop_s})
      2'b10:   level_nxt_s = fifo_level_s + LVL_ONE;
      2'b01:   level_nxt_s = fifo_level_s - LVL_ONE;
      default: level_nxt_s = fifo_level_s;
    endcase
    case (state_nxt_s)
      START:   tx_nxt_s = 1'b0;
      DATA:    tx_nxt_s = shift_nxt_s[0];
      default: tx_nxt_s = 1'b1;
    endcase
    busy_nxt_s = (state_nxt_s != IDLE) || (level_nxt_s != {LVL_WIDTH{1'b0}});
  end

  // Registered line and busy outputs; reset drives the line to idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= tx_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (push_i && fifo_full_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

endmodule
